conv5x5_window_mac: RTL and testbench
=====================================

Name: conv5x5_window_mac

Overview:
- Downstream consumer of the 5-row line buffer. Takes the newest pixel plus the four delayed row outputs and assembles a 5x5 sliding window in registers.
- Computes the signed 25-tap MAC plus bias, then requantises with ReLU to an 8-bit feature pixel. This is the C1 convolution stage of the LeNet-5 datapath: 32x32 input gives a 28x28 feature map.

Parameters:
- IMG_WIDTH, 32, pixels per input row.
- IMG_HEIGHT, 32, rows per input frame.
- SHIFT, 7, right-shift applied to the accumulator during requantisation (range 1..15).

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- rst  in  1  asynchronous active-high reset.
- valid_in  in  1  one pixel column is presented on row0..row4.
- row0  in  8  unsigned pixel, current row y (newest).
- row1..row4  in  8 each  unsigned pixels of rows y-1..y-4, same column.
- w_we  in  1  weight write strobe.
- w_addr  in  5  weight index 0..24, computed as r*5+c.
- w_data  in  8  signed weight.
- b_we  in  1  bias write strobe.
- b_data  in  16  signed bias.
- acc_out  out  24  signed sum of 25 products plus bias.
- pix_out  out  8  requantised, ReLU'd, saturated result.
- out_x  out  5  output column 0..27.
- out_y  out  5  output row 0..27.
- valid_out  out  1  acc_out, pix_out, out_x and out_y are valid this cycle.
- frame_done  out  1  one-cycle pulse, coincident with the valid_out of output (27,27).

Behaviour:
- Reset: all outputs 0. Window registers, x/y counters, pipeline valid bits, weights and bias all cleared. Reset takes effect immediately (async) and may be asserted mid-frame; the following frame restarts at pixel (0,0).
- Counters: x/y count accepted valid_in beats. x wraps at IMG_WIDTH-1, which increments y. y wraps at IMG_HEIGHT-1 back to 0 (next frame).
- Window stage S0: on valid_in, each window row shifts left by one column and the new column enters at c=4.
  - Window row r=0 (top) takes row4; window row r=4 takes row0.
  - So w_addr 0 multiplies pixel (x-4,y-4) and w_addr 24 multiplies pixel (x,y).
  - On a cycle without valid_in the window holds.
- Window-complete flag: set when the sampled beat has x>=4 and y>=4. The flag carries out_x=x-4 and out_y=y-4 into the pipeline.
- Pipeline: S1 registers 25 products, S2 registers 5 row sums, S3 adds bias, S4 requantises.
  - Each stage advances every cycle; a valid bit travels alongside the data.
  - Latency: valid_out is high exactly 4 cycles after the cycle of the completing valid_in beat.
  - Gaps in valid_in create bubbles only; results must match gapless input.
- Arithmetic:
  - Each pixel is zero-extended to 9-bit signed; each product is 17-bit signed.
  - The 25-term sum is sign-extended to 24 bits; bias is sign-extended 16 to 24.
  - No overflow is possible.
- Requantisation: t = (acc + 2^(SHIFT-1)) >>> SHIFT, using an arithmetic shift. pix_out = 0 if t<0, 255 if t>255, else t.
- Weight/bias writes take effect the cycle after the strobe. There is no hazard protection; load between frames. Simultaneous w_we and b_we are both honoured.
- Exactly (IMG_WIDTH-4)*(IMG_HEIGHT-4) = 784 valid_out pulses per frame.

Decomposition:
- Package cnn_pkg:
  - Constants K=5, PIX_W=8, W_W=8, PROD_W=17, ACC_W=24, BIAS_W=16.
  - A saturating requantise function.
  - A weight-array typedef (25 x signed 8).
- Sub-module conv_mac_tree (stages S1–S3): inputs are the window, weights, bias and valid; outputs are acc and valid. The top level keeps the counters, window shifting, coordinate pipeline, requantisation and frame_done.

Test Plan:
- Only w[24]=1, bias 0, pixel(x,y)=x+y.
  - First valid_out comes 4 cycles after beat 132 (x=4,y=4), with acc_out=8 and out_x=out_y=0.
  - Every subsequent acc_out equals the input pixel at (out_x+4, out_y+4).
  - 784 outputs in total.
- All weights 1, all pixels 255, bias 0 -> acc_out=6375, pix_out=50 (SHIFT=7).
- All weights -128, pixels 255 -> acc_out=-816000, pix_out=0. All weights 127, bias 100 -> acc_out=809725, pix_out=255.
- Test 1 repeated with valid_in deasserted on random ~30% of cycles -> identical acc_out/out_x/out_y sequence; valid_out latency stays 4 cycles after each completing beat.
- Assert rst for one cycle at row 10 of a frame:
  - valid_out, acc_out and pix_out drop to 0 immediately.
  - Weights read back as zero (acc_out=0 on the next frame unless reloaded).
  - After reloading weights, the first output again follows beat 132 of the new stream.
- Two back-to-back frames without idle cycles -> frame_done pulses exactly twice, each with out_x=out_y=27, and the second frame's first output has out_x=out_y=0.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared widths, window/weight containers and the requantise helper
// for the LeNet-5 C1 convolution stage.
package cnn_pkg;
    localparam int K        = 5;
    localparam int TAPS     = K * K;
    localparam int PIX_W    = 8;
    localparam int W_W      = 8;
    localparam int PROD_W   = 17;
    localparam int ROWSUM_W = PROD_W + 3;
    localparam int ACC_W    = 24;
    localparam int BIAS_W   = 16;

    localparam logic signed [ACC_W:0] PIX_MAX_S = (ACC_W+1)'(255);

    typedef logic [TAPS-1:0][W_W-1:0]   weight_arr_t;
    typedef logic [TAPS-1:0][PIX_W-1:0] window_t;

    // Round-half-up, arithmetic shift, then clamp to 0..255 (ReLU + saturate).
    function automatic logic [PIX_W-1:0] requantise(input logic signed [ACC_W-1:0] acc,
                                                    input int shift);
        logic signed [ACC_W:0] rnd;
        logic signed [ACC_W:0] t;
        rnd = (ACC_W+1)'(1) <<< (shift - 1);
        t   = ($signed({acc[ACC_W-1], acc}) + rnd) >>> shift;
        if (t[ACC_W])
            return '0;
        else if (t > PIX_MAX_S)
            return '1;
        else
            return t[PIX_W-1:0];
    endfunction
endpackage

// File: rtl/conv_mac_tree.sv
// Three-stage signed MAC: 25 products, 5 row sums, then total plus bias.
module conv_mac_tree
    import cnn_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_valid,
    input  window_t                  i_win,
    input  weight_arr_t              i_w,
    input  logic signed [BIAS_W-1:0] i_bias,
    output logic signed [ACC_W-1:0]  o_acc,
    output logic                     o_valid
);
    logic signed [PROD_W-1:0]   r_prod [TAPS];
    logic signed [ROWSUM_W-1:0] r_rsum [K];
    logic signed [ACC_W-1:0]    r_acc;
    logic                       r_v1, r_v2, r_v3;
    logic signed [ROWSUM_W-1:0] w_rsum [K];
    logic signed [ACC_W-1:0]    w_sum;

    always_comb begin
        for (int r = 0; r < K; r++) begin
            w_rsum[r] = '0;
            for (int c = 0; c < K; c++)
                w_rsum[r] = w_rsum[r] + ROWSUM_W'(r_prod[r*K+c]);
        end
        w_sum = ACC_W'(i_bias);
        for (int r = 0; r < K; r++)
            w_sum = w_sum + ACC_W'(r_rsum[r]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < TAPS; i++) r_prod[i] <= '0;
            for (int r = 0; r < K; r++)    r_rsum[r] <= '0;
            r_acc <= '0;
            r_v1  <= 1'b0;
            r_v2  <= 1'b0;
            r_v3  <= 1'b0;
        end else begin
            // Pixels are unsigned, so zero-extend before the signed multiply.
            for (int i = 0; i < TAPS; i++)
                r_prod[i] <= $signed({1'b0, i_win[i]}) * $signed(i_w[i]);
            for (int r = 0; r < K; r++)
                r_rsum[r] <= w_rsum[r];
            r_acc <= w_sum;
            r_v1  <= i_valid;
            r_v2  <= r_v1;
            r_v3  <= r_v2;
        end
    end

    assign o_acc   = r_acc;
    assign o_valid = r_v3;
endmodule

// File: rtl/conv5x5_window_mac.sv
// 5x5 sliding window over the line-buffer columns feeding the MAC tree,
// with raster counters, output coordinates and requantised pixel output.
module conv5x5_window_mac
    import cnn_pkg::*;
#(
    parameter int IMG_WIDTH  = 32,
    parameter int IMG_HEIGHT = 32,
    parameter int SHIFT      = 7
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid_in,
    input  logic [PIX_W-1:0]        row0,
    input  logic [PIX_W-1:0]        row1,
    input  logic [PIX_W-1:0]        row2,
    input  logic [PIX_W-1:0]        row3,
    input  logic [PIX_W-1:0]        row4,
    input  logic                    w_we,
    input  logic [4:0]              w_addr,
    input  logic [W_W-1:0]          w_data,
    input  logic                    b_we,
    input  logic [BIAS_W-1:0]       b_data,
    output logic signed [ACC_W-1:0] acc_out,
    output logic [PIX_W-1:0]        pix_out,
    output logic [4:0]              out_x,
    output logic [4:0]              out_y,
    output logic                    valid_out,
    output logic                    frame_done
);
    logic [4:0]               r_x, r_y;
    window_t                  r_win;
    weight_arr_t              r_wt;
    logic signed [BIAS_W-1:0] r_bias;
    logic                     r_v0;
    logic [4:0]               r_ox [4];
    logic [4:0]               r_oy [4];
    logic [PIX_W-1:0]         w_col [K];
    logic signed [ACC_W-1:0]  w_acc;
    logic                     w_v3;

    // Window row 0 is the oldest line, so the column enters bottom-up.
    assign w_col[0] = row4;
    assign w_col[1] = row3;
    assign w_col[2] = row2;
    assign w_col[3] = row1;
    assign w_col[4] = row0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x    <= '0;
            r_y    <= '0;
            r_win  <= '0;
            r_wt   <= '0;
            r_bias <= '0;
            r_v0   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_ox[i] <= '0;
                r_oy[i] <= '0;
            end
        end else begin
            if (w_we && (w_addr < 5'(TAPS)))
                r_wt[w_addr] <= w_data;
            if (b_we)
                r_bias <= b_data;

            r_v0 <= valid_in && (r_x >= 5'd4) && (r_y >= 5'd4);
            if (valid_in) begin
                for (int r = 0; r < K; r++) begin
                    for (int c = 0; c < K-1; c++)
                        r_win[r*K+c] <= r_win[r*K+c+1];
                    r_win[r*K+K-1] <= w_col[r];
                end
                r_ox[0] <= r_x - 5'd4;
                r_oy[0] <= r_y - 5'd4;
                if (r_x == 5'(IMG_WIDTH-1)) begin
                    r_x <= '0;
                    r_y <= (r_y == 5'(IMG_HEIGHT-1)) ? 5'd0 : r_y + 5'd1;
                end else begin
                    r_x <= r_x + 5'd1;
                end
            end
            for (int i = 1; i < 4; i++) begin
                r_ox[i] <= r_ox[i-1];
                r_oy[i] <= r_oy[i-1];
            end
        end
    end

    conv_mac_tree u_tree (
        .clk     (clk),
        .rst     (rst),
        .i_valid (r_v0),
        .i_win   (r_win),
        .i_w     (r_wt),
        .i_bias  (r_bias),
        .o_acc   (w_acc),
        .o_valid (w_v3)
    );

    assign acc_out    = w_acc;
    assign pix_out    = requantise(w_acc, SHIFT);
    assign valid_out  = w_v3;
    assign out_x      = r_ox[3];
    assign out_y      = r_oy[3];
    assign frame_done = w_v3 && (r_ox[3] == 5'(IMG_WIDTH-5)) && (r_oy[3] == 5'(IMG_HEIGHT-5));
endmodule

// File: tb/tb_conv5x5_window_mac.sv
// Directed bench: uniform-window vector table, ramp frames with a scoreboard
// monitor, gapped input, mid-frame reset and back-to-back frames.
module tb_conv5x5_window_mac;
    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               valid_in = 1'b0;
    logic [7:0]         row0 = '0, row1 = '0, row2 = '0, row3 = '0, row4 = '0;
    logic               w_we = 1'b0;
    logic [4:0]         w_addr = '0;
    logic [7:0]         w_data = '0;
    logic               b_we = 1'b0;
    logic [15:0]        b_data = '0;
    logic signed [23:0] acc_out;
    logic [7:0]         pix_out;
    logic [4:0]         out_x, out_y;
    logic               valid_out, frame_done;

    conv5x5_window_mac dut (
        .clk(clk), .rst(rst), .valid_in(valid_in),
        .row0(row0), .row1(row1), .row2(row2), .row3(row3), .row4(row4),
        .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
        .b_we(b_we), .b_data(b_data),
        .acc_out(acc_out), .pix_out(pix_out), .out_x(out_x), .out_y(out_y),
        .valid_out(valid_out), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic check(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard state for ramp frames: pixel(x,y)=x+y, only w[24] nonzero.
    bit   mon_en = 1'b0;
    int   gain   = 1;
    int   ex = 0, ey = 0, n_out = 0, n_fd = 0;
    int   lat_q[$];

    task automatic mon_clear();
        ex = 0; ey = 0; n_out = 0; n_fd = 0;
        lat_q.delete();
    endtask

    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (valid_out) begin
                n_out++;
                check("ox", out_x, ex);
                check("oy", out_y, ey);
                check("acc", acc_out, gain * (ex + ey + 8));
                check("pix", pix_out, 0);
                check("fd", frame_done, (ex == 27 && ey == 27) ? 1 : 0);
                if (frame_done) n_fd++;
                if (lat_q.size() > 0) check("lat", cyc, lat_q.pop_front());
                else                  check("lat_q_empty", lat_q.size(), 1);
                if (ex == 27) begin
                    ex = 0;
                    ey = (ey == 27) ? 0 : ey + 1;
                end else begin
                    ex++;
                end
            end else if (frame_done) begin
                check("fd_stray", frame_done, 0);
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1; valid_in = 1'b0; w_we = 1'b0; b_we = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic write_w(input int addr, input int val);
        w_we = 1'b1; w_addr = 5'(addr); w_data = 8'(val);
        tick();
        w_we = 1'b0;
    endtask

    // All 25 weights = wv; bias is written in the same cycle as weight 0.
    task automatic load_uniform(input int wv, input int b);
        for (int i = 0; i < 25; i++) begin
            w_we = 1'b1; w_addr = 5'(i); w_data = 8'(wv);
            b_we = (i == 0); b_data = 16'(b);
            tick();
        end
        w_we = 1'b0; b_we = 1'b0;
    endtask

    task automatic flush();
        valid_in = 1'b0;
        repeat (10) tick();
    endtask

    task automatic drive_frame(input int gap_pct, input int stop_row);
        for (int y = 0; y < 32; y++) begin
            for (int x = 0; x < 32; x++) begin
                if (y == stop_row && x == 10) begin
                    valid_in = 1'b0;
                    return;
                end
                while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
                    valid_in = 1'b0;
                    row0 = 8'($urandom); row1 = 8'($urandom); row2 = 8'($urandom);
                    row3 = 8'($urandom); row4 = 8'($urandom);
                    tick();
                end
                valid_in = 1'b1;
                row0 = 8'(x + y);
                row1 = (y >= 1) ? 8'(x + y - 1) : 8'd0;
                row2 = (y >= 2) ? 8'(x + y - 2) : 8'd0;
                row3 = (y >= 3) ? 8'(x + y - 3) : 8'd0;
                row4 = (y >= 4) ? 8'(x + y - 4) : 8'd0;
                if (x >= 4 && y >= 4) lat_q.push_back(cyc + 4);
                tick();
            end
        end
        valid_in = 1'b0;
    endtask

    typedef struct {
        int     wv;
        int     b;
        int     p;
        longint exp_acc;
        int     exp_pix;
    } vec_t;

    vec_t vecs[12];

    initial begin
        #200_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   t_exp;
        bit   seen;

        vecs[0]  = '{1,    0,      255, 6375,    50};
        vecs[1]  = '{-128, 0,      255, -816000, 0};
        vecs[2]  = '{127,  100,    255, 809725,  255};
        vecs[3]  = '{0,    -200,   7,   -200,    0};
        vecs[4]  = '{0,    63,     9,   63,      0};
        vecs[5]  = '{0,    64,     9,   64,      1};
        vecs[6]  = '{0,    32575,  0,   32575,   254};
        vecs[7]  = '{0,    32704,  0,   32704,   255};
        vecs[8]  = '{1,    -2436,  100, 64,      1};
        vecs[9]  = '{-1,   0,      3,   -75,     0};
        vecs[10] = '{2,    -564,   10,  -64,     0};
        vecs[11] = '{3,    -14000, 200, 1000,    8};

        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", valid_out, 0);
        check("rst_acc", acc_out, 0);
        check("rst_pix", pix_out, 0);
        check("rst_ox", out_x, 0);
        check("rst_oy", out_y, 0);
        check("rst_fd", frame_done, 0);
        rst = 1'b0;

        // Uniform windows: first window completes on beat 132.
        foreach (vecs[i]) begin
            do_reset();
            load_uniform(vecs[i].wv, vecs[i].b);
            t_exp = 0;
            for (int n = 0; n < 133; n++) begin
                valid_in = 1'b1;
                row0 = 8'(vecs[i].p); row1 = 8'(vecs[i].p); row2 = 8'(vecs[i].p);
                row3 = 8'(vecs[i].p); row4 = 8'(vecs[i].p);
                if (n == 132) t_exp = cyc + 4;
                tick();
            end
            valid_in = 1'b0;
            seen = 1'b0;
            for (int k = 0; k < 12 && !seen; k++) begin
                @(negedge clk);
                if (valid_out) seen = 1'b1;
            end
            check($sformatf("vec%0d_seen", i), seen, 1);
            if (seen) begin
                check($sformatf("vec%0d_lat", i), cyc, t_exp);
                check($sformatf("vec%0d_acc", i), acc_out, vecs[i].exp_acc);
                check($sformatf("vec%0d_pix", i), pix_out, vecs[i].exp_pix);
                check($sformatf("vec%0d_ox", i), out_x, 0);
                check($sformatf("vec%0d_oy", i), out_y, 0);
            end
            tick();
        end

        // Two gapless back-to-back ramp frames.
        do_reset();
        write_w(24, 1);
        mon_clear();
        gain = 1;
        mon_en = 1'b1;
        drive_frame(0, -1);
        drive_frame(0, -1);
        flush();
        check("b2b_outs", n_out, 1568);
        check("b2b_fd", n_fd, 2);
        check("b2b_pending", lat_q.size(), 0);

        // Same ramp with ~30% bubbles.
        mon_clear();
        drive_frame(30, -1);
        flush();
        check("gap_outs", n_out, 784);
        check("gap_fd", n_fd, 1);
        check("gap_pending", lat_q.size(), 0);

        // Reset in the middle of row 10 while outputs are streaming.
        mon_clear();
        drive_frame(0, 10);
        check("pre_rst_valid", valid_out, 1);
        mon_en = 1'b0;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", valid_out, 0);
        check("mid_rst_acc", acc_out, 0);
        check("mid_rst_pix", pix_out, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        mon_clear();
        gain = 0;
        mon_en = 1'b1;
        drive_frame(0, -1);
        flush();
        check("zero_w_outs", n_out, 784);

        write_w(24, 1);
        mon_clear();
        gain = 1;
        drive_frame(0, -1);
        flush();
        check("reload_outs", n_out, 784);
        check("reload_fd", n_fd, 1);
        mon_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
